wave_seq_ctrl: RTL and testbench



---
 rtl/wave_seq_ctrl.sv | 151 +++++++++++++++
 tb/tb_wave_seq_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/wave_seq_ctrl.sv
// wave_seq_ctrl: walks ROM sample address across a latched symbol sequence; define WAVE_SEQ_GAP_EN for idle gaps between symbols
module wave_seq_ctrl #(
    parameter int SAMPLES = 2498,
    parameter int SYMS = 8,
    parameter int REP_W = 8,
    parameter int GAP = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        abort,
    input  logic [SYMS-1:0]             seq_in,
    input  logic [REP_W-1:0]            reps_in,
    output logic                        busy,
    output logic                        done,
    output logic                        sample_en,
    output logic [$clog2(SAMPLES)-1:0]  addr,
    output logic                        sym_sel,
    output logic [$clog2(SYMS)-1:0]     sym_idx,
    output logic                        frame_start
);
    localparam int AW = $clog2(SAMPLES);
    localparam int SW = $clog2(SYMS);
    localparam logic [AW-1:0] ADDR_LAST = AW'(SAMPLES - 1);
    localparam logic [SW-1:0] SYM_LAST = SW'(SYMS - 1);
`ifdef WAVE_SEQ_GAP_EN
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_GAP} state_t;
    logic [GW-1:0] gap_cnt;
`else
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
`endif
    state_t state;
    logic armed;
    logic [SYMS-1:0] seq;
    logic [REP_W-1:0] reps;
    logic [REP_W-1:0] rep_cnt;
    logic last_sample;
    logic last_sym;
    logic finish;
    logic [SW-1:0] nxt_sym;
    logic [REP_W-1:0] nxt_rep;
    always_comb begin
        last_sample = addr == ADDR_LAST;
        last_sym = sym_idx == SYM_LAST;
        finish = last_sample && last_sym && !(reps == '0 || rep_cnt < reps);
        nxt_sym = last_sym ? '0 : sym_idx + SW'(1);
        nxt_rep = !last_sym ? rep_cnt : (rep_cnt == '1) ? rep_cnt : rep_cnt + REP_W'(1);
    end
    // armed holds the accepted start for one cycle so the first sample lands one cycle after acceptance
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            armed <= 1'b0;
            seq <= '0;
            reps <= '0;
            rep_cnt <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            sample_en <= 1'b0;
            addr <= '0;
            sym_sel <= 1'b0;
            sym_idx <= '0;
            frame_start <= 1'b0;
`ifdef WAVE_SEQ_GAP_EN
            gap_cnt <= '0;
`endif
        end else begin
            done <= 1'b0;
            frame_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (abort) begin
                        armed <= 1'b0;
                    end else if (armed) begin
                        armed <= 1'b0;
                        state <= S_RUN;
                        busy <= 1'b1;
                        sample_en <= 1'b1;
                        frame_start <= 1'b1;
                        addr <= '0;
                        sym_idx <= '0;
                        sym_sel <= seq[0];
                        rep_cnt <= REP_W'(1);
                    end else if (start) begin
                        seq <= seq_in;
                        reps <= reps_in;
                        armed <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        state <= S_IDLE;
                        busy <= 1'b0;
                        sample_en <= 1'b0;
                        addr <= '0;
                        sym_idx <= '0;
                        sym_sel <= 1'b0;
                    end else if (!last_sample) begin
                        addr <= addr + AW'(1);
                    end else if (finish) begin
                        state <= S_DONE;
                        done <= 1'b1;
                        busy <= 1'b0;
                        sample_en <= 1'b0;
                        addr <= '0;
                        sym_idx <= '0;
                        sym_sel <= 1'b0;
                    end else begin
                        addr <= '0;
                        sym_idx <= nxt_sym;
                        rep_cnt <= nxt_rep;
`ifdef WAVE_SEQ_GAP_EN
                        if (GAP > 0) begin
                            state <= S_GAP;
                            gap_cnt <= '0;
                            sample_en <= 1'b0;
                            sym_sel <= 1'b0;
                        end else begin
                            frame_start <= 1'b1;
                            sym_sel <= seq[nxt_sym];
                        end
`else
                        frame_start <= 1'b1;
                        sym_sel <= seq[nxt_sym];
`endif
                    end
                end
`ifdef WAVE_SEQ_GAP_EN
                S_GAP: begin
                    if (abort) begin
                        state <= S_IDLE;
                        busy <= 1'b0;
                        sym_idx <= '0;
                    end else if (gap_cnt == GAP_LAST) begin
                        state <= S_RUN;
                        sample_en <= 1'b1;
                        frame_start <= 1'b1;
                        sym_sel <= seq[sym_idx];
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
`endif
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wave_seq_ctrl.sv
// tb_wave_seq_ctrl: directed self-checking bench for wave_seq_ctrl (SAMPLES=4, SYMS=3, REP_W=4, GAP=2)
module tb_wave_seq_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic [2:0] seq_in = '0;
    logic [3:0] reps_in = '0;
    logic busy, done, sample_en, sym_sel, frame_start;
    logic [1:0] addr, sym_idx;
    logic [8:0] obs;
    int checks = 0;
    int errors = 0;
    always #5 clk = ~clk;
    wave_seq_ctrl #(.SAMPLES(4), .SYMS(3), .REP_W(4), .GAP(2)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .seq_in(seq_in), .reps_in(reps_in),
        .busy(busy), .done(done), .sample_en(sample_en), .addr(addr), .sym_sel(sym_sel),
        .sym_idx(sym_idx), .frame_start(frame_start)
    );
    assign obs = {sample_en, busy, done, frame_start, sym_sel, sym_idx, addr};
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic launch(input logic [2:0] s, input logic [3:0] r);
        seq_in = s;
        reps_in = r;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask
    function automatic logic [8:0] exp_play(input int i, input logic [2:0] s);
        int a;
        int y;
        a = i % 4;
        y = (i / 4) % 3;
        return {1'b1, 1'b1, 1'b0, a == 0, s[y], 2'(y), 2'(a)};
    endfunction
    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (obs !== 9'b0) begin errors++; $display("FAIL reset_hold obs=%b exp=%b", obs, 9'b0); end
        rst = 1'b0;
        tick();
        checks++;
        if (obs !== 9'b0) begin errors++; $display("FAIL reset_release obs=%b exp=%b", obs, 9'b0); end
    endtask
    task automatic test_single();
        logic [2:0] s;
        logic [8:0] e;
        s = 3'b101;
        launch(s, 4'd1);
        checks++;
        if (obs !== 9'b0) begin errors++; $display("FAIL single_latency obs=%b exp=%b", obs, 9'b0); end
        for (int i = 0; i < 12; i++) begin
            tick();
            e = exp_play(i, s);
            checks++;
            if (obs !== e) begin errors++; $display("FAIL single_sample%0d obs=%b exp=%b", i, obs, e); end
        end
        tick();
        checks++;
        if (obs !== 9'b001000000) begin errors++; $display("FAIL single_done obs=%b exp=%b", obs, 9'b001000000); end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (obs !== 9'b0) begin errors++; $display("FAIL single_done_clear obs=%b exp=%b", obs, 9'b0); end
        tick();
        checks++;
        if (obs !== 9'b0) begin errors++; $display("FAIL start_in_done obs=%b exp=%b", obs, 9'b0); end
    endtask
    task automatic test_repeat();
        logic [2:0] s;
        logic [8:0] e;
        int fs;
        s = 3'b110;
        fs = 0;
        launch(s, 4'd3);
        for (int i = 0; i < 36; i++) begin
            tick();
            e = exp_play(i, s);
            fs += int'(frame_start);
            checks++;
            if (obs !== e) begin errors++; $display("FAIL repeat_sample%0d obs=%b exp=%b", i, obs, e); end
        end
        checks++;
        if (fs != 9) begin errors++; $display("FAIL repeat_frames count=%0d exp=9", fs); end
        tick();
        checks++;
        if (obs !== 9'b001000000) begin errors++; $display("FAIL repeat_done obs=%b exp=%b", obs, 9'b001000000); end
        tick();
        checks++;
        if (obs !== 9'b0) begin errors++; $display("FAIL repeat_idle obs=%b exp=%b", obs, 9'b0); end
    endtask
    task automatic test_abort();
        logic [2:0] s;
        logic [8:0] e;
        int seen_done;
        s = 3'b011;
        seen_done = 0;
        launch(s, 4'd0);
        for (int i = 0; i < 50; i++) begin
            tick();
            e = exp_play(i, s);
            checks++;
            if (obs !== e) begin errors++; $display("FAIL cont_sample%0d obs=%b exp=%b", i, obs, e); end
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (obs !== 9'b0) begin errors++; $display("FAIL abort_idle obs=%b exp=%b", obs, 9'b0); end
        for (int i = 0; i < 4; i++) begin
            tick();
            seen_done += int'(done | busy | sample_en);
        end
        checks++;
        if (seen_done != 0) begin errors++; $display("FAIL abort_no_done active=%0d exp=0", seen_done); end
    endtask
    task automatic test_ignore();
        logic [2:0] s;
        logic [8:0] e;
        s = 3'b101;
        launch(s, 4'd1);
        for (int i = 0; i < 12; i++) begin
            tick();
            start = 1'b0;
            e = exp_play(i, s);
            checks++;
            if (obs !== e) begin errors++; $display("FAIL ignore_sample%0d obs=%b exp=%b", i, obs, e); end
            if (i == 2) begin
                start = 1'b1;
                seq_in = 3'b010;
                reps_in = 4'd5;
            end
        end
        tick();
        checks++;
        if (obs !== 9'b001000000) begin errors++; $display("FAIL ignore_done obs=%b exp=%b", obs, 9'b001000000); end
    endtask
    task automatic test_start_abort();
        seq_in = 3'b111;
        reps_in = 4'd1;
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        checks++;
        if (obs !== 9'b0) begin errors++; $display("FAIL start_abort_1 obs=%b exp=%b", obs, 9'b0); end
        tick();
        tick();
        checks++;
        if (obs !== 9'b0) begin errors++; $display("FAIL start_abort_2 obs=%b exp=%b", obs, 9'b0); end
    endtask
    task automatic test_rst_mid();
        logic [2:0] s;
        logic [8:0] e;
        s = 3'b101;
        launch(s, 4'd1);
        for (int i = 0; i < 6; i++) tick();
        e = exp_play(5, s);
        checks++;
        if (obs !== e) begin errors++; $display("FAIL rst_pre obs=%b exp=%b", obs, e); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (obs !== 9'b0) begin errors++; $display("FAIL rst_mid obs=%b exp=%b", obs, 9'b0); end
        tick();
        checks++;
        if (obs !== 9'b0) begin errors++; $display("FAIL rst_mid_after obs=%b exp=%b", obs, 9'b0); end
    endtask
`ifdef WAVE_SEQ_GAP_EN
    task automatic test_gap();
        logic [2:0] s;
        logic [8:0] e;
        int k;
        s = 3'b001;
        launch(s, 4'd1);
        for (int c = 0; c < 16; c++) begin
            tick();
            if (c == 4 || c == 5 || c == 10 || c == 11) begin
                checks++;
                if ((obs & 9'b111110011) !== 9'b010000000) begin errors++; $display("FAIL gap_idle%0d obs=%b exp=%b", c, obs, 9'b010000000); end
            end else begin
                k = (c < 4) ? c : (c < 10) ? c - 2 : c - 4;
                e = exp_play(k, s);
                checks++;
                if (obs !== e) begin errors++; $display("FAIL gap_sample%0d obs=%b exp=%b", c, obs, e); end
            end
        end
        tick();
        checks++;
        if (obs !== 9'b001000000) begin errors++; $display("FAIL gap_done obs=%b exp=%b", obs, 9'b001000000); end
        tick();
    endtask
`endif
    initial begin
        test_reset();
        test_single();
        test_repeat();
        test_abort();
        test_ignore();
        tick();
        test_start_abort();
        test_rst_mid();
`ifdef WAVE_SEQ_GAP_EN
        test_gap();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
